// File: rtl/fifo_uart_framer.sv
// Drains words from the async FIFO read port and frames them for uart_tx: sync byte, then data bytes MSB first.
// Optional trailing XOR checksum byte when FRAME_CHKSUM_EN is defined.
module fifo_uart_framer #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_ff_empty,
  output logic                  o_ff_rd_inc,
  input  logic [WORD_WIDTH-1:0] i_ff_data,
  input  logic                  i_sig_done,
  output logic [7:0]            o_txbyte,
  output logic                  o_txsend,
  input  logic                  i_txdone,
  input  logic                  i_txactive,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_word_count
);

  localparam int unsigned DATA_BYTES  = WORD_WIDTH / 8;
`ifdef FRAME_CHKSUM_EN
  localparam int unsigned FRAME_BYTES = DATA_BYTES + 2;
`else
  localparam int unsigned FRAME_BYTES = DATA_BYTES + 1;
`endif
  localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOAD,
    ST_WAIT_TX,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  rd_inc_q, rd_inc_d;
  logic                  txsend_q, txsend_d;
  logic [7:0]            txbyte_q, txbyte_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  fetch_q, fetch_d;
  logic [7:0]            tx_byte_c;

`ifdef FRAME_CHKSUM_EN
  logic [7:0] chksum_c;

  // XOR of the data bytes; sync byte is not covered
  always_comb begin
    chksum_c = 8'h00;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      chksum_c = chksum_c ^ word_q[8*i +: 8];
    end
  end
`endif

  // Byte for the current frame index
  always_comb begin
    tx_byte_c = SYNC_BYTE;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (idx_q == IDX_W'(i + 1)) begin
        tx_byte_c = word_q[WORD_WIDTH-1-8*i -: 8];
      end
    end
`ifdef FRAME_CHKSUM_EN
    if (idx_q == LAST_IDX) begin
      tx_byte_c = chksum_c;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    rd_inc_d = 1'b0;
    txsend_d = 1'b0;
    txbyte_d = txbyte_q;
    busy_d   = busy_q;
    done_d   = done_q;
    count_d  = count_q;
    word_d   = word_q;
    idx_d    = idx_q;
    fetch_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!i_ff_empty) begin
          rd_inc_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_LATCH;
        end else if (i_sig_done) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_LATCH: begin
        word_d  = i_ff_data;
        fetch_d = 1'b1;
        idx_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Re-sample once in the cycle after the read pulse, where the FIFO guarantees valid data
        if (fetch_q) begin
          word_d = i_ff_data;
        end
        if (!i_txactive && !txsend_q) begin
          txsend_d = 1'b1;
          txbyte_d = tx_byte_c;
          state_d  = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (i_txdone) begin
          if (idx_q == LAST_IDX) begin
            count_d = count_q + CNT_WIDTH'(1);
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      rd_inc_q <= 1'b0;
      txsend_q <= 1'b0;
      txbyte_q <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      fetch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_inc_q <= rd_inc_d;
      txsend_q <= txsend_d;
      txbyte_q <= txbyte_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      fetch_q  <= fetch_d;
    end
  end

  assign o_ff_rd_inc  = rd_inc_q;
  assign o_txsend     = txsend_q;
  assign o_txbyte     = txbyte_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_word_count = count_q;

endmodule

// File: tb/tb_fifo_uart_framer.sv
// Bench for fifo_uart_framer: queue-based FIFO and uart_tx models, expected byte stream built from framing rules.
module tb_fifo_uart_framer;

  localparam int unsigned BIT_CYC = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ff_empty;
  logic        ff_rd_inc;
  logic [31:0] ff_data;
  logic        sig_done;
  logic [7:0]  txbyte;
  logic        txsend;
  logic        txdone;
  logic        txactive;
  logic        busy;
  logic        done;
  logic [15:0] word_count;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int uphase = 0;
  int ucnt   = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  fifo_uart_framer dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_ff_empty   (ff_empty),
    .o_ff_rd_inc  (ff_rd_inc),
    .i_ff_data    (ff_data),
    .i_sig_done   (sig_done),
    .o_txbyte     (txbyte),
    .o_txsend     (txsend),
    .i_txdone     (txdone),
    .i_txactive   (txactive),
    .o_busy       (busy),
    .o_done       (done),
    .o_word_count (word_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected frame: sync, data bytes MSB first, optional XOR of data bytes
  function automatic void add_frame(input logic [31:0] w);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 3; k >= 0; k--) begin
      b = 8'(w >> (8 * k));
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef FRAME_CHKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  function automatic void push_word(input logic [31:0] w, input bit expect_frame);
    fifo_q.push_back(w);
    ff_empty = 1'b0;
    if (expect_frame) add_frame(w);
  endfunction

  // One clock: observe outputs at the falling edge, then advance FIFO and uart_tx models
  task automatic tick();
    @(negedge clk);
    if (txsend) begin
      chk("send_while_active", 64'(txactive), 64'd0);
      got.push_back(txbyte);
    end
    if (ff_rd_inc) chk("rd_while_empty", 64'(ff_empty), 64'd0);
    txdone = 1'b0;
    if (txsend) begin
      txactive = 1'b1;
      uphase   = 1;
      ucnt     = BIT_CYC;
    end else begin
      case (uphase)
        1: if (ucnt == 0) begin uphase = 2; txdone = 1'b1; end else ucnt--;
        2: uphase = 3;
        3: begin uphase = 0; txactive = 1'b0; end
        default: ;
      endcase
    end
    if (ff_rd_inc && fifo_q.size() > 0) begin
      ff_data = fifo_q.pop_front();
      pops++;
    end
    ff_empty = (fifo_q.size() == 0);
  endtask

  task automatic clear_models();
    txactive = 1'b0;
    txdone   = 1'b0;
    uphase   = 0;
    ucnt     = 0;
    sig_done = 1'b0;
    fifo_q.delete();
    got.delete();
    exp_q.delete();
    ff_empty = 1'b1;
    ff_data  = 32'h0;
    pops     = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_models();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic wait_count(input logic [15:0] n, input int budget);
    int k;
    k = 0;
    while (word_count !== n && k < budget) begin
      tick();
      k++;
    end
    chk("word_count", 64'(word_count), 64'(n));
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk($sformatf("%s_len", tag), 64'(got.size()), 64'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int k;
    logic [31:0] w;
    rstn = 1'b0;
    clear_models();
    #12;
    chk("rst_rd_inc", 64'(ff_rd_inc), 64'd0);
    chk("rst_txbyte", 64'(txbyte), 64'd0);
    chk("rst_txsend", 64'(txsend), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(word_count), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Single word, first send within 3 cycles of the FIFO going non-empty
    push_word(32'h1234_5678, 1'b1);
    k = 0;
    while (got.size() == 0 && k < 3) begin
      tick();
      k++;
    end
    chk("first_send_latency", 64'(got.size()), 64'd1);
    chk("busy_in_frame", 64'(busy), 64'd1);
    wait_count(16'd1, 400);
    check_stream("single");
    chk("single_pops", 64'(pops), 64'd1);
    chk("single_busy_after", 64'(busy), 64'd0);

    // Back-to-back directed words plus random words
    push_word(32'h0000_0001, 1'b1);
    push_word(32'hFFFF_FFFF, 1'b1);
    push_word(32'h8000_0000, 1'b1);
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b1);
    wait_count(16'd7, 2000);
    check_stream("b2b");
    chk("b2b_pops", 64'(pops), 64'd7);
    chk("b2b_busy_after", 64'(busy), 64'd0);

    // Reset after the second byte's send request abandons the frame
    push_word($urandom, 1'b0);
    k = 0;
    while (got.size() < 2 && k < 100) begin
      tick();
      k++;
    end
    chk("mid_reached_byte2", 64'(got.size()), 64'd2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_txsend", 64'(txsend), 64'd0);
    chk("mid_rst_txbyte", 64'(txbyte), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rd_inc", 64'(ff_rd_inc), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_count", 64'(word_count), 64'd0);
    clear_models();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("mid_no_send_after", 64'(got.size()), 64'd0);

    // Counter wraps from all-ones to zero
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    chk("wrap_preload", 64'(word_count), 64'hFFFF);
    w = $urandom;
    push_word(w, 1'b1);
    wait_count(16'h0000, 400);
    check_stream("wrap");

    // Completion with an empty FIFO, then ignore later data
    do_reset();
    sig_done = 1'b1;
    tick();
    tick();
    chk("done_set", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    push_word($urandom, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("done_no_pops", 64'(pops), 64'd0);
    chk("done_no_send", 64'(got.size()), 64'd0);
    chk("done_sticky", 64'(done), 64'd1);

    // Data wins over done when both arrive together
    do_reset();
    push_word(32'hCAFE_BABE, 1'b1);
    sig_done = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    chk("prio_done", 64'(done), 64'd1);
    chk("prio_count", 64'(word_count), 64'd1);
    chk("prio_pops", 64'(pops), 64'd1);
    check_stream("prio");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
